npc_btb: RTL and testbench
==========================

# npc_btb

Parametrised next-PC unit with integrated fetch PC register and direct-mapped branch target buffer (BTB) with 2-bit saturating counters. It sits at the fetch stage. It predicts the next fetch address every cycle and accepts resolved control-flow outcomes from the EX/MEM stage. On a misprediction it redirects fetch and raises a flush. It generalises the combinational next-PC selector to configurable width and depth, and adds dynamic prediction.

## Interface
Parameters:
- WIDTH, 32, address/data width in bits.
- ENTRIES, 16, number of BTB entries. Must be a power of 2, at least 2. IDX = log2(ENTRIES).
- RESET_PC, 0, fetch address loaded on reset.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- stall  in  1  hold pc_f (hazard stall).
- pc_f  out  WIDTH  current fetch PC (registered).
- pred_next_f  out  WIDTH  predicted next PC for pc_f. Carried down the pipeline with the instruction.
- pred_hit_f  out  1  BTB hit and counter[1]=1 for pc_f.
- ex_valid  in  1  EX/MEM holds a valid, non-squashed instruction.
- ex_pc  in  WIDTH  PC of that instruction.
- ex_npcop  in  3  resolved next-PC op: 000 PLUS4, 001 BRANCH taken, 010 JUMP (jal), 100 JALR. Other codes are treated as PLUS4.
- ex_is_cond  in  1  instruction is a conditional branch (taken or not).
- ex_imm  in  WIDTH  branch/jal offset.
- ex_aluout  in  WIDTH  jalr target from the ALU.
- ex_pred_next  in  WIDTH  pred_next_f value carried with the instruction.
- flush  out  1  misprediction detected. Combinational from the ex_* inputs.
- perf_br  out  32  resolved control-flow count (see Configuration).
- perf_mis  out  32  misprediction count (see Configuration).

## Operation
Address fields:
- Index = pc[IDX+1:2].
- Tag = pc[WIDTH-1:IDX+2].

Each entry holds: valid, tag, target[WIDTH-1:0], ctr[1:0].

Lookup (combinational on pc_f):
- Hit = valid && tag match.
- If hit && ctr[1]: pred_next_f = target and pred_hit_f = 1.
- Otherwise: pred_next_f = pc_f + 4 and pred_hit_f = 0.

Actual next PC:
- BRANCH or JUMP: ex_pc + ex_imm.
- JALR: {ex_aluout[WIDTH-1:1], 1'b0}.
- Otherwise: ex_pc + 4.
- All adds are modulo 2^WIDTH and wrap silently.

Misprediction:
- flush = ex_valid && (actual_next != ex_pred_next).

Next pc_f, in priority order:
1. rst → RESET_PC.
2. flush → actual_next. Overrides stall.
3. stall → hold.
4. Otherwise → pred_next_f.

BTB update (ex_valid and cflow, where cflow = ex_is_cond || npcop ∈ {JUMP, JALR}):
- Existing entry hit at ex_pc:
  - Taken: ctr increments, saturating at 11, and target is rewritten to actual_next.
  - Not taken: ctr decrements, saturating at 00.
- Miss and taken: allocate by overwriting the indexed entry with valid=1, tag, target. ctr = 10 for a conditional branch, 11 for JUMP/JALR.
- Miss and not taken: no change.
- JUMP/JALR on a hit: ctr forced to 11.
- Non-cflow instructions never touch the BTB.

## Timing
- Reset (asynchronous, immediate): pc_f = RESET_PC, all valid bits = 0, perf_br = perf_mis = 0. pred_next_f = RESET_PC + 4, pred_hit_f = 0.
- Prediction latency: 0 cycles. pred_next_f is valid in the same cycle as pc_f.
- Redirect latency: flush is asserted in the cycle the ex_* inputs are presented; pc_f = actual_next after the next edge.
- BTB write occurs at the edge ending the update cycle. A lookup of the same index in that cycle sees the old contents (read-before-write).
- Simultaneous stall and flush: flush wins and pc_f is redirected.
- rst asserted mid-operation: all state cleared at once; any pending update is lost.
- Upstream must drive ex_valid = 0 for instructions squashed by a flush.

## Configuration
- NPC_PERF_EN defined:
  - perf_br increments on every ex_valid && cflow.
  - perf_mis increments on every flush.
  - Both are 32-bit, wrap modulo 2^32, and update on the same edge as the BTB.
- NPC_PERF_EN undefined: no counter registers are built, and perf_br and perf_mis are tied to 0. All other behaviour is identical.

## Test plan
- Reset: assert rst with RESET_PC=32'h0000_3000 → pc_f=3000, pred_next_f=3004, pred_hit_f=0. Release with stall=0 → pc_f sequence 3004, 3008.
- Cold taken branch:
  - Stimulus: ex_valid, ex_pc=3010, ex_is_cond, npcop=001, imm=-16, ex_pred_next=3014.
  - Response: flush=1 and next pc_f=3000. Entry index 4 gets target 3000, ctr=10.
  - When pc_f later reaches 3010: pred_hit_f=1, pred_next_f=3000.
- Counter training: resolve branch 3010 not-taken twice (pred 3000) → flush each time, ctr 10→01→00. The next fetch of 3010 predicts 3014.
- JALR: ex_pc=3020, npcop=100, aluout=32'h0000_4005, ex_pred_next=3024 → flush=1, next pc_f=4004, entry allocated with ctr=11.
- Stall vs flush: stall=1 with no flush → pc_f held for 3 cycles. stall=1 together with a flush → redirect still taken.
- With NPC_PERF_EN: the previous sequence gives expected perf_br/perf_mis counts. Without it, both read 0 throughout.

Source files
------------

// File: rtl/npc_btb.sv
// rtl/npc_btb.sv - fetch PC register, next-PC prediction and direct-mapped BTB with 2-bit counters
// Performance counters are built only when NPC_PERF_EN is defined; otherwise perf_br/perf_mis read 0.
module npc_btb #(
  parameter int               WIDTH    = 32,
  parameter int               ENTRIES  = 16,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  output logic [WIDTH-1:0] pc_f,
  output logic [WIDTH-1:0] pred_next_f,
  output logic             pred_hit_f,
  input  logic             ex_valid,
  input  logic [WIDTH-1:0] ex_pc,
  input  logic [2:0]       ex_npcop,
  input  logic             ex_is_cond,
  input  logic [WIDTH-1:0] ex_imm,
  input  logic [WIDTH-1:0] ex_aluout,
  input  logic [WIDTH-1:0] ex_pred_next,
  output logic             flush,
  output logic [31:0]      perf_br,
  output logic [31:0]      perf_mis
);

  localparam int IDX  = $clog2(ENTRIES);
  localparam int TAGW = WIDTH - IDX - 2;

  localparam logic [2:0] OP_BRANCH = 3'b001;
  localparam logic [2:0] OP_JUMP   = 3'b010;
  localparam logic [2:0] OP_JALR   = 3'b100;

  localparam logic [WIDTH-1:0] FOUR     = WIDTH'(4);
  localparam logic [WIDTH-1:0] LSB_MASK = ~WIDTH'(1);

  logic [ENTRIES-1:0] btb_valid;
  logic [TAGW-1:0]    btb_tag    [ENTRIES];
  logic [WIDTH-1:0]   btb_target [ENTRIES];
  logic [1:0]         btb_ctr    [ENTRIES];

  // Fetch-side lookup
  logic [IDX-1:0]  f_idx;
  logic [TAGW-1:0] f_tag;
  logic            f_hit;

  assign f_idx = pc_f[IDX+1:2];
  assign f_tag = pc_f[WIDTH-1:IDX+2];
  assign f_hit = btb_valid[f_idx] && (btb_tag[f_idx] == f_tag);

  always_comb begin
    pred_hit_f  = f_hit && btb_ctr[f_idx][1];
    pred_next_f = pc_f + FOUR;
    if (pred_hit_f) pred_next_f = btb_target[f_idx];
  end

  // Resolution of the instruction in EX/MEM
  logic             is_jump;
  logic             taken;
  logic             cflow;
  logic [WIDTH-1:0] actual_next;

  always_comb begin
    is_jump = (ex_npcop == OP_JUMP) || (ex_npcop == OP_JALR);
    taken   = is_jump || (ex_npcop == OP_BRANCH);
    cflow   = ex_is_cond || is_jump;
    case (ex_npcop)
      OP_BRANCH, OP_JUMP: actual_next = ex_pc + ex_imm;
      OP_JALR:            actual_next = ex_aluout & LSB_MASK;
      default:            actual_next = ex_pc + FOUR;
    endcase
  end

  assign flush = ex_valid && (actual_next != ex_pred_next);

  // BTB update: train on hits, allocate only on taken misses
  logic            upd;
  logic [IDX-1:0]  e_idx;
  logic [TAGW-1:0] e_tag;
  logic            e_hit;
  logic            wr_en;
  logic [1:0]      ctr_nxt;

  assign upd   = ex_valid && cflow;
  assign e_idx = ex_pc[IDX+1:2];
  assign e_tag = ex_pc[WIDTH-1:IDX+2];
  assign e_hit = btb_valid[e_idx] && (btb_tag[e_idx] == e_tag);
  assign wr_en = upd && (e_hit || taken);

  always_comb begin
    ctr_nxt = btb_ctr[e_idx];
    if (!e_hit) begin
      ctr_nxt = is_jump ? 2'b11 : 2'b10;
    end else if (is_jump) begin
      ctr_nxt = 2'b11;
    end else if (taken) begin
      if (btb_ctr[e_idx] != 2'b11) ctr_nxt = btb_ctr[e_idx] + 2'b01;
    end else begin
      if (btb_ctr[e_idx] != 2'b00) ctr_nxt = btb_ctr[e_idx] - 2'b01;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btb_valid <= '0;
    end else if (wr_en && taken) begin
      btb_valid[e_idx] <= 1'b1;
    end
  end

  // Payload arrays need no reset: an entry is ignored until its valid bit is set.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      btb_ctr[e_idx] <= ctr_nxt;
      if (taken) begin
        btb_tag[e_idx]    <= e_tag;
        btb_target[e_idx] <= actual_next;
      end
    end
  end

  // Fetch PC: redirect beats stall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_f <= RESET_PC;
    end else if (flush) begin
      pc_f <= actual_next;
    end else if (!stall) begin
      pc_f <= pred_next_f;
    end
  end

`ifdef NPC_PERF_EN
  logic [31:0] br_cnt;
  logic [31:0] mis_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_cnt  <= '0;
      mis_cnt <= '0;
    end else begin
      if (upd)   br_cnt  <= br_cnt + 32'd1;
      if (flush) mis_cnt <= mis_cnt + 32'd1;
    end
  end

  assign perf_br  = br_cnt;
  assign perf_mis = mis_cnt;
`else
  assign perf_br  = '0;
  assign perf_mis = '0;
`endif

endmodule

// File: tb/tb_npc_btb.sv
// tb/tb_npc_btb.sv - directed and randomized checks of npc_btb against a behavioural BTB model
module tb_npc_btb;

  localparam int N    = 16;
  localparam int IDXB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic [31:0] pc_f, pred_next_f;
  logic        pred_hit_f;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [2:0]  ex_npcop;
  logic        ex_is_cond;
  logic [31:0] ex_imm, ex_aluout, ex_pred_next;
  logic        flush;
  logic [31:0] perf_br, perf_mis;

  int total = 0;
  int bad   = 0;

  npc_btb #(.WIDTH(32), .ENTRIES(N), .RESET_PC(32'h0000_3000)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .pc_f(pc_f), .pred_next_f(pred_next_f), .pred_hit_f(pred_hit_f),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_npcop(ex_npcop), .ex_is_cond(ex_is_cond),
    .ex_imm(ex_imm), .ex_aluout(ex_aluout), .ex_pred_next(ex_pred_next),
    .flush(flush), .perf_br(perf_br), .perf_mis(perf_mis)
  );

  always #5 clk = ~clk;

  // Reference model: BTB as plain arrays, counters as integers 0..3
  logic [31:0] m_pc;
  bit          m_valid  [N];
  logic [31:0] m_tag    [N];
  logic [31:0] m_target [N];
  int          m_ctr    [N];
  logic [31:0] m_br, m_mis;

  logic [31:0] e_pred, e_actual, e_br, e_mis;
  logic        e_hit, e_flush;

  logic [2:0] ops [6] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd3, 3'd7};

  function automatic logic [31:0] ref_actual(logic [31:0] pc, logic [2:0] op, logic [31:0] imm, logic [31:0] alu);
    if (op == 3'd1 || op == 3'd2) return pc + imm;
    if (op == 3'd4) return alu & 32'hFFFF_FFFE;
    return pc + 32'd4;
  endfunction

  function automatic int slot(logic [31:0] a);
    return int'((a >> 2) % N);
  endfunction

  function automatic logic [31:0] tag_of(logic [31:0] a);
    return a >> (2 + IDXB);
  endfunction

  function void model_reset();
    m_pc = 32'h0000_3000;
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 0; m_tag[i] = '0; m_target[i] = '0; m_ctr[i] = 0;
    end
    m_br = '0; m_mis = '0;
  endfunction

  function void model_comb();
    int i;
    i = slot(m_pc);
    e_hit    = m_valid[i] && (m_tag[i] == tag_of(m_pc)) && (m_ctr[i] >= 2);
    e_pred   = e_hit ? m_target[i] : m_pc + 32'd4;
    e_actual = ref_actual(ex_pc, ex_npcop, ex_imm, ex_aluout);
    e_flush  = ex_valid && (e_actual != ex_pred_next);
`ifdef NPC_PERF_EN
    e_br = m_br; e_mis = m_mis;
`else
    e_br = '0; e_mis = '0;
`endif
  endfunction

  function void model_clock();
    bit jmp, tkn;
    int i;
    jmp = (ex_npcop == 3'd2) || (ex_npcop == 3'd4);
    tkn = jmp || (ex_npcop == 3'd1);
    if (ex_valid && (ex_is_cond || jmp)) begin
      i = slot(ex_pc);
      if (m_valid[i] && m_tag[i] == tag_of(ex_pc)) begin
        if (tkn) begin
          m_ctr[i] = jmp ? 3 : ((m_ctr[i] < 3) ? m_ctr[i] + 1 : 3);
          m_target[i] = e_actual;
        end else begin
          m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
        end
      end else if (tkn) begin
        m_valid[i] = 1; m_tag[i] = tag_of(ex_pc); m_target[i] = e_actual; m_ctr[i] = jmp ? 3 : 2;
      end
      m_br = m_br + 32'd1;
    end
    if (e_flush) begin
      m_mis = m_mis + 32'd1;
      m_pc  = e_actual;
    end else if (!stall) begin
      m_pc = e_pred;
    end
  endfunction

  task automatic drive(input bit s, input bit v, input logic [31:0] pc, input logic [2:0] op,
                       input bit cond, input logic [31:0] imm, input logic [31:0] alu, input logic [31:0] pn);
    stall = s; ex_valid = v; ex_pc = pc; ex_npcop = op; ex_is_cond = cond;
    ex_imm = imm; ex_aluout = alu; ex_pred_next = pn;
  endtask

  task automatic idle(input bit s);
    drive(s, 0, 32'h0, 3'd0, 0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic settle();
    #4;
    model_comb();
  endtask

  task automatic tick();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(0);
    model_reset();
    @(posedge clk); #1;
    total++; if (pc_f !== 32'h3000) begin bad++; $display("FAIL reset_pc: got %h want 00003000", pc_f); end
    total++; if (pred_next_f !== 32'h3004) begin bad++; $display("FAIL reset_pred: got %h want 00003004", pred_next_f); end
    total++; if (pred_hit_f !== 1'b0) begin bad++; $display("FAIL reset_hit: got %b want 0", pred_hit_f); end
    total++; if (perf_br !== 32'h0 || perf_mis !== 32'h0) begin bad++; $display("FAIL reset_perf: got %0d/%0d want 0/0", perf_br, perf_mis); end
    rst = 1'b0;
    settle();
    tick();
    settle();
    total++; if (pc_f !== 32'h3004) begin bad++; $display("FAIL reset_seq1: got %h want 00003004", pc_f); end
    tick();
    settle();
    total++; if (pc_f !== 32'h3008) begin bad++; $display("FAIL reset_seq2: got %h want 00003008", pc_f); end
    tick();
  endtask

  task automatic test_cold_branch();
    bool_found: begin end
    drive(0, 1, 32'h3010, 3'd1, 1, 32'hFFFF_FFF0, 32'h0, 32'h3014);
    settle();
    total++; if (flush !== 1'b1) begin bad++; $display("FAIL cold_flush: got %b want 1", flush); end
    tick();
    idle(0);
    settle();
    total++; if (pc_f !== 32'h3000) begin bad++; $display("FAIL cold_redirect: got %h want 00003000", pc_f); end
    for (int n = 0; n < 8 && pc_f !== 32'h3010; n++) begin
      tick();
      settle();
    end
    total++;
    if (pc_f !== 32'h3010) begin
      bad++; $display("FAIL cold_reach_timeout: pc_f %h want 00003010", pc_f);
    end else if (pred_hit_f !== 1'b1 || pred_next_f !== 32'h3000) begin
      bad++; $display("FAIL cold_predict: got hit=%b next=%h want hit=1 next=00003000", pred_hit_f, pred_next_f);
    end
    tick();
  endtask

  task automatic test_training();
    for (int k = 0; k < 2; k++) begin
      drive(0, 1, 32'h3010, 3'd0, 1, 32'hFFFF_FFF0, 32'h0, 32'h3000);
      settle();
      total++; if (flush !== 1'b1) begin bad++; $display("FAIL train_flush%0d: got %b want 1", k, flush); end
      tick();
    end
    drive(0, 1, 32'h300C, 3'd0, 0, 32'h0, 32'h0, 32'h0);
    settle();
    tick();
    idle(0);
    settle();
    total++; if (pc_f !== 32'h3010) begin bad++; $display("FAIL train_pc: got %h want 00003010", pc_f); end
    total++; if (pred_hit_f !== 1'b0 || pred_next_f !== 32'h3014) begin bad++; $display("FAIL train_predict: got hit=%b next=%h want hit=0 next=00003014", pred_hit_f, pred_next_f); end
    tick();
  endtask

  task automatic test_jalr();
    drive(0, 1, 32'h3020, 3'd4, 0, 32'h0, 32'h0000_4005, 32'h3024);
    settle();
    total++; if (flush !== 1'b1) begin bad++; $display("FAIL jalr_flush: got %b want 1", flush); end
    tick();
    idle(0);
    settle();
    total++; if (pc_f !== 32'h4004) begin bad++; $display("FAIL jalr_pc: got %h want 00004004", pc_f); end
    tick();
    drive(0, 1, 32'h301C, 3'd0, 0, 32'h0, 32'h0, 32'h0);
    settle();
    tick();
    idle(0);
    settle();
    total++; if (pc_f !== 32'h3020 || pred_hit_f !== 1'b1 || pred_next_f !== 32'h4004) begin bad++; $display("FAIL jalr_predict: got pc=%h hit=%b next=%h want pc=00003020 hit=1 next=00004004", pc_f, pred_hit_f, pred_next_f); end
    tick();
  endtask

  task automatic test_stall();
    logic [31:0] held;
    logic [31:0] want_br, want_mis;
    idle(1);
    held = m_pc;
    for (int k = 0; k < 3; k++) begin
      tick();
      settle();
      total++; if (pc_f !== held) begin bad++; $display("FAIL stall_hold%0d: got %h want %h", k, pc_f, held); end
    end
    drive(1, 1, 32'h5000, 3'd0, 0, 32'h0, 32'h0, 32'h0);
    settle();
    total++; if (flush !== 1'b1) begin bad++; $display("FAIL stall_flush: got %b want 1", flush); end
    tick();
    idle(0);
    settle();
    total++; if (pc_f !== 32'h5004) begin bad++; $display("FAIL stall_redirect: got %h want 00005004", pc_f); end
`ifdef NPC_PERF_EN
    want_br = 32'd4; want_mis = 32'd7;
`else
    want_br = 32'd0; want_mis = 32'd0;
`endif
    total++; if (perf_br !== want_br || perf_mis !== want_mis) begin bad++; $display("FAIL perf_directed: got %0d/%0d want %0d/%0d", perf_br, perf_mis, want_br, want_mis); end
    tick();
  endtask

  task automatic test_random(input int cycles);
    logic [31:0] pc, imm, alu, pn;
    logic [2:0]  op;
    for (int c = 0; c < cycles; c++) begin
      pc  = ($urandom_range(0, 19) == 0) ? 32'hFFFF_FFFC : 32'h3000 + 32'($urandom_range(0, 127)) * 32'd4;
      op  = ops[$urandom_range(0, 5)];
      imm = 32'($urandom_range(0, 63)) * 32'd4 - 32'd128;
      alu = $urandom;
      pn  = $urandom_range(0, 1) ? ref_actual(pc, op, imm, alu) : pc + 32'($urandom_range(0, 3)) * 32'd4;
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 9) < 7, pc, op, 1'($urandom_range(0, 1)), imm, alu, pn);
      settle();
      total++; if (pc_f !== m_pc) begin bad++; $display("FAIL rand_pc c%0d: got %h want %h", c, pc_f, m_pc); end
      total++; if (pred_next_f !== e_pred || pred_hit_f !== e_hit) begin bad++; $display("FAIL rand_pred c%0d: got %h/%b want %h/%b", c, pred_next_f, pred_hit_f, e_pred, e_hit); end
      total++; if (flush !== e_flush) begin bad++; $display("FAIL rand_flush c%0d: got %b want %b", c, flush, e_flush); end
      total++; if (perf_br !== e_br || perf_mis !== e_mis) begin bad++; $display("FAIL rand_perf c%0d: got %0d/%0d want %0d/%0d", c, perf_br, perf_mis, e_br, e_mis); end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    drive(0, 1, 32'h3040, 3'd1, 1, 32'h40, 32'h0, 32'h0);
    #2;
    rst = 1'b1;
    idle(0);
    #1;
    total++; if (pc_f !== 32'h3000 || pred_hit_f !== 1'b0 || pred_next_f !== 32'h3004) begin bad++; $display("FAIL midrst_async: got pc=%h hit=%b next=%h want 00003000/0/00003004", pc_f, pred_hit_f, pred_next_f); end
    total++; if (perf_br !== 32'h0 || perf_mis !== 32'h0) begin bad++; $display("FAIL midrst_perf: got %0d/%0d want 0/0", perf_br, perf_mis); end
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    drive(0, 1, 32'h303C, 3'd0, 0, 32'h0, 32'h0, 32'h0);
    settle();
    tick();
    idle(0);
    settle();
    total++; if (pc_f !== 32'h3040 || pred_hit_f !== 1'b0 || pred_next_f !== 32'h3044) begin bad++; $display("FAIL midrst_lost_update: got pc=%h hit=%b next=%h want 00003040/0/00003044", pc_f, pred_hit_f, pred_next_f); end
    tick();
  endtask

  initial begin
    test_reset();
    test_cold_branch();
    test_training();
    test_jalr();
    test_stall();
    test_random(300);
    test_reset_mid();
    test_random(150);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
